i2sout: RTL and testbench

- I2S master transmitter: generates ws and sd from the bit clock sck, streaming 2-channel PCM to a DAC or to the team's i2sin receiver.
- Samples arrive from the mixer core over a valid/ready interface, tagged left/right, and are buffered one deep per channel.
- Any channel whose buffer is empty at its slot start transmits silence and flags an underrun.

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2sout_chan_buf.sv | 55 +++++
 rtl/i2sout.sv | 147 ++++++++++++++
 tb/tb_i2sout.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit path.
//
// Contents:
//   BITS_PRECISION_DEFAULT - default sample word width
//   SLOT_BITS_DEFAULT      - default sck cycles per channel slot
//   CH_LEFT / CH_RIGHT     - channel tag values; they are also the ws level for each slot
//   slot_cnt_width()       - width of the in-slot bit counter
package i2s_pkg;

    localparam int unsigned BITS_PRECISION_DEFAULT = 24;
    localparam int unsigned SLOT_BITS_DEFAULT      = 32;

    // ws is high during the left slot, so the tag value and the ws level coincide.
    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;

    // Counter width for 0..slot_bits-1. Never returns less than one bit.
    function automatic int unsigned slot_cnt_width(input int unsigned slot_bits);
        return (slot_bits > 1) ? $clog2(slot_bits) : 1;
    endfunction

endpackage

// File: rtl/i2sout_chan_buf.sv
// One-entry sample holding register with a full flag, used once per channel.
//
// Ports:
//   clk_i      - bit clock (sck)
//   rst_ni     - asynchronous active-low reset; empties the buffer
//   wr_en_i    - write strobe; the caller only asserts it while the buffer is empty
//   wr_data_i  - sample to store
//   ld_i       - the shift register is taking the stored word this edge; clears full
//   full_o     - buffer holds a word not yet sent
//   data_o     - stored word
//
// When ld_i and wr_en_i coincide the reader gets the old contents (held in data_o
// before the edge) and the new word is kept with full set.
module i2sout_chan_buf #(
    parameter int unsigned Width = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             ld_i,
    output logic             full_o,
    output logic [Width-1:0] data_o
);

    logic             full_q, full_d;
    logic [Width-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (ld_i) begin
            full_d = 1'b0;
        end
        // A write on the load edge wins so the new word is not lost.
        if (wr_en_i) begin
            full_d = 1'b1;
            data_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/i2sout.sv
// I2S master transmitter. Generates ws and sd from sck and streams two-channel
// PCM, MSB first, with the standard one-bit delay after each ws transition.
//
// Ports:
//   sck                - bit clock; all state changes on its rising edge
//   rstn               - asynchronous active-low reset
//   sample_data        - two's-complement sample from the mixer
//   sample_left_rightn - channel tag of the offered sample (1 = left, 0 = right)
//   sample_valid       - sample offered
//   sample_ready       - the tagged channel's buffer is free (depends on the tag only)
//   ws                 - word select, 1 during the left slot
//   sd                 - serial data
//   underrun           - one-cycle pulse when a slot starts with an empty buffer
//
// Each slot is SLOT_BITS cycles. The edge that wraps bit_cnt to 0 toggles ws and
// moves the new channel's buffered word into the shift register (zeros plus an
// underrun pulse if that buffer is empty). sd is 0 at bit_cnt 0, carries the word
// MSB first at bit_cnt 1..BITS_PRECISION, and is 0 for the rest of the slot.
// SLOT_BITS must be at least BITS_PRECISION+1 so the whole word fits in the slot.
module i2sout
    import i2s_pkg::*;
#(
    parameter int unsigned BITS_PRECISION = BITS_PRECISION_DEFAULT,
    parameter int unsigned SLOT_BITS      = SLOT_BITS_DEFAULT
) (
    input  logic                      sck,
    input  logic                      rstn,
    input  logic [BITS_PRECISION-1:0] sample_data,
    input  logic                      sample_left_rightn,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int unsigned         CntW    = slot_cnt_width(SLOT_BITS);
    localparam logic [CntW-1:0]     CntLast = CntW'(SLOT_BITS - 1);

    logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                      ws_q, ws_d;
    logic [BITS_PRECISION-1:0] shift_q, shift_d;
    logic                      sd_q, sd_d;
    logic                      underrun_q, underrun_d;

    logic                      full_left, full_right;
    logic [BITS_PRECISION-1:0] data_left, data_right;

    logic                      slot_end;
    logic                      next_ch;
    logic                      ld_left, ld_right;
    logic                      accept;
    logic                      wr_left, wr_right;
    logic                      ld_full;
    logic [BITS_PRECISION-1:0] ld_data;

    // ------------------------------------------------------------------
    // Handshake and buffers
    // ------------------------------------------------------------------

    // Ready looks only at the tag so the mixer can probe a channel without
    // committing to a transfer.
    assign sample_ready = (sample_left_rightn == CH_LEFT) ? ~full_left : ~full_right;
    assign accept       = sample_valid & sample_ready;
    assign wr_left      = accept & (sample_left_rightn == CH_LEFT);
    assign wr_right     = accept & (sample_left_rightn == CH_RIGHT);

    // The slot that starts on this edge belongs to the channel ws is about to show.
    assign slot_end = (bit_cnt_q == CntLast);
    assign next_ch  = ~ws_q;
    assign ld_left  = slot_end & (next_ch == CH_LEFT);
    assign ld_right = slot_end & (next_ch == CH_RIGHT);

    i2sout_chan_buf #(
        .Width (BITS_PRECISION)
    ) u_buf_left (
        .clk_i     (sck),
        .rst_ni    (rstn),
        .wr_en_i   (wr_left),
        .wr_data_i (sample_data),
        .ld_i      (ld_left),
        .full_o    (full_left),
        .data_o    (data_left)
    );

    i2sout_chan_buf #(
        .Width (BITS_PRECISION)
    ) u_buf_right (
        .clk_i     (sck),
        .rst_ni    (rstn),
        .wr_en_i   (wr_right),
        .wr_data_i (sample_data),
        .ld_i      (ld_right),
        .full_o    (full_right),
        .data_o    (data_right)
    );

    // Pre-edge view of the buffer feeding the next slot. A sample accepted on
    // the same edge is not visible here and waits for that channel's next slot.
    assign ld_full = (next_ch == CH_LEFT) ? full_left : full_right;
    assign ld_data = (next_ch == CH_LEFT) ? data_left : data_right;

    // ------------------------------------------------------------------
    // Slot counter, word select and serialiser
    // ------------------------------------------------------------------

    always_comb begin
        bit_cnt_d  = bit_cnt_q + CntW'(1);
        ws_d       = ws_q;
        // Shifting in zeros makes sd fall to 0 on its own once the word is out.
        shift_d    = {shift_q[BITS_PRECISION-2:0], 1'b0};
        sd_d       = shift_q[BITS_PRECISION-1];
        underrun_d = 1'b0;

        if (slot_end) begin
            bit_cnt_d  = '0;
            ws_d       = next_ch;
            // One-bit delay: the first cycle of every slot carries 0.
            sd_d       = 1'b0;
            shift_d    = ld_full ? ld_data : '0;
            underrun_d = ~ld_full;
        end
    end

    // bit_cnt resets to its last value so the first edge after reset opens a
    // left slot.
    always_ff @(posedge sck or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_q  <= CntLast;
            ws_q       <= 1'b0;
            shift_q    <= '0;
            sd_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            ws_q       <= ws_d;
            shift_q    <= shift_d;
            sd_q       <= sd_d;
            underrun_q <= underrun_d;
        end
    end

    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2sout.sv
// Bench for i2sout: a reference model of the slot schedule and buffers queues the
// word each slot should carry; a serial receiver decodes sd/ws and checks each
// slot against that queue. A vector table drives the mixer side; short
// hand-written sequences cover reset, collision and mid-frame reset.
module tb_i2sout;
    import i2s_pkg::*;

    localparam int unsigned BP = 24;
    localparam int unsigned SB = 32;

    logic          sck = 1'b0;
    logic          rstn;
    logic [BP-1:0] sample_data;
    logic          sample_left_rightn;
    logic          sample_valid;
    logic          sample_ready;
    logic          ws;
    logic          sd;
    logic          underrun;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic          ch;
        logic [BP-1:0] word;
        logic          und;
    } slot_t;

    typedef struct {
        logic          lr;
        logic [BP-1:0] data;
        logic [BP-1:0] exp_word;
    } vec_t;

    slot_t exp_q[$];

    // Reference model state
    int unsigned   m_cnt;
    logic          m_ws;
    logic [1:0]    m_full;
    logic [BP-1:0] m_buf [2];
    logic [BP-1:0] drv_exp;

    // Receiver state
    slot_t         cur;
    logic [BP-1:0] rx_word;
    logic          tail_bad;
    logic          have_slot = 1'b0;

    always #5 sck = ~sck;

    i2sout #(
        .BITS_PRECISION (BP),
        .SLOT_BITS      (SB)
    ) dut (
        .sck                (sck),
        .rstn               (rstn),
        .sample_data        (sample_data),
        .sample_left_rightn (sample_left_rightn),
        .sample_valid       (sample_valid),
        .sample_ready       (sample_ready),
        .ws                 (ws),
        .sd                 (sd),
        .underrun           (underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Model: slot schedule and per-channel one-deep buffers.
    always @(posedge sck or negedge rstn) begin
        if (!rstn) begin
            m_cnt  <= SB - 1;
            m_ws   <= 1'b0;
            m_full <= 2'b00;
            exp_q.delete();
        end else begin
            if (m_cnt == SB - 1) begin
                m_cnt <= 0;
                m_ws  <= ~m_ws;
                exp_q.push_back(slot_t'{ch: ~m_ws,
                                        word: m_full[~m_ws] ? m_buf[~m_ws] : {BP{1'b0}},
                                        und: ~m_full[~m_ws]});
                m_full[~m_ws] <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (sample_valid && !m_full[sample_left_rightn]) begin
                m_full[sample_left_rightn] <= 1'b1;
                m_buf[sample_left_rightn]  <= drv_exp;
            end
        end
    end

    // Receiver: samples on the falling edge, away from the launching edge.
    always @(negedge sck) begin
        if (!rstn) begin
            have_slot = 1'b0;
        end else if (m_cnt == 0) begin
            if (exp_q.size() == 0) begin
                fail_now("slot_expect", "actual no queued slot, required one");
                have_slot = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                check("ws_at_slot_start", 32'(ws), 32'(cur.ch));
                check("underrun_at_slot_start", 32'(underrun), 32'(cur.und));
                have_slot = 1'b1;
                rx_word   = '0;
                tail_bad  = sd;
            end
        end else if (have_slot) begin
            if (m_cnt <= BP) begin
                rx_word = {rx_word[BP-2:0], sd};
            end else begin
                tail_bad = tail_bad | sd;
            end
            if (m_cnt == 1) check("underrun_one_cycle", 32'(underrun), 32'd0);
            if (m_cnt == BP) check("slot_word", 32'(rx_word), 32'(cur.word));
            if (m_cnt == SB - 1) begin
                check("slot_zero_padding", 32'(tail_bad), 32'd0);
                check("ws_held_in_slot", 32'(ws), 32'(cur.ch));
            end
        end
    end

    // Ready must track the tagged channel's buffer state every cycle.
    always @(negedge sck) begin
        #2;
        if (rstn) begin
            check("sample_ready", 32'(sample_ready), 32'(!m_full[sample_left_rightn]));
        end
    end

    // Offer a sample and hold it until the model says it was taken.
    task automatic push(input logic lr, input logic [BP-1:0] data, input logic [BP-1:0] exp_word);
        bit done = 1'b0;
        sample_left_rightn = lr;
        sample_data        = data;
        drv_exp            = exp_word;
        sample_valid       = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            #1;
            done = !m_full[lr];
            @(negedge sck);
        end
        sample_valid = 1'b0;
        if (!done) fail_now("push_timeout", "actual never accepted, required acceptance");
    endtask

    task automatic wait_slot(input logic w, input int unsigned c);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge sck);
            if (m_ws == w && m_cnt == c) hit = 1'b1;
        end
        if (!hit) fail_now("wait_slot_timeout", "actual position not reached, required reached");
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{lr: 1'b1, data: 24'h000001, exp_word: 24'h000001};
        tbl[1] = '{lr: 1'b1, data: 24'h000002, exp_word: 24'h000002};
        tbl[2] = '{lr: 1'b1, data: 24'h000003, exp_word: 24'h000003};
        tbl[3] = '{lr: 1'b0, data: 24'h7FFFFF, exp_word: 24'h7FFFFF};
        tbl[4] = '{lr: 1'b1, data: 24'h800000, exp_word: 24'h800000};
        tbl[5] = '{lr: 1'b0, data: 24'hFFFFFF, exp_word: 24'hFFFFFF};
        tbl[6] = '{lr: 1'b1, data: 24'h000000, exp_word: 24'h000000};
        tbl[7] = '{lr: 1'b0, data: 24'h555555, exp_word: 24'h555555};
        tbl[8] = '{lr: 1'b1, data: 24'hAAAAAA, exp_word: 24'hAAAAAA};
        tbl[9] = '{lr: 1'b0, data: 24'hC0FFEE, exp_word: 24'hC0FFEE};

        rstn               = 1'b0;
        sample_valid       = 1'b0;
        sample_left_rightn = CH_LEFT;
        sample_data        = '0;
        drv_exp            = '0;

        // Reset values
        #12;
        check("reset_ws", 32'(ws), 32'd0);
        check("reset_sd", 32'(sd), 32'd0);
        check("reset_underrun", 32'(underrun), 32'd0);
        check("reset_ready_left", 32'(sample_ready), 32'd1);
        sample_left_rightn = CH_RIGHT;
        #1;
        check("reset_ready_right", 32'(sample_ready), 32'd1);

        // Release, offering left on the edge that opens the first left slot:
        // that slot underruns and the word goes out one frame later.
        @(negedge sck);
        rstn = 1'b1;
        push(CH_LEFT, 24'hABCDEF, 24'hABCDEF);
        check("first_edge_ws", 32'(ws), 32'd1);
        check("first_edge_underrun", 32'(underrun), 32'd1);
        push(CH_RIGHT, 24'h123456, 24'h123456);

        // Table: back-to-back lefts exercise backpressure, then mixed extremes.
        for (int i = 0; i < 10; i++) begin
            push(tbl[i].lr, tbl[i].data, tbl[i].exp_word);
        end
        repeat (200) @(negedge sck);

        // Reset mid-frame with both buffers full
        wait_slot(CH_RIGHT, 5);
        push(CH_RIGHT, 24'h0F0F0F, 24'h0F0F0F);
        push(CH_LEFT, 24'hF0F0F0, 24'hF0F0F0);
        wait_slot(CH_LEFT, 3);
        push(CH_LEFT, 24'h333333, 24'h333333);
        wait_slot(CH_LEFT, 10);
        sample_left_rightn = CH_LEFT;
        #1;
        check("ready_left_full", 32'(sample_ready), 32'd0);
        sample_left_rightn = CH_RIGHT;
        #1;
        check("ready_right_full", 32'(sample_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("midreset_ws", 32'(ws), 32'd0);
        check("midreset_sd", 32'(sd), 32'd0);
        check("midreset_underrun", 32'(underrun), 32'd0);
        check("midreset_ready_right", 32'(sample_ready), 32'd1);
        sample_left_rightn = CH_LEFT;
        #1;
        check("midreset_ready_left", 32'(sample_ready), 32'd1);
        @(negedge sck);
        @(negedge sck);
        rstn = 1'b1;
        @(negedge sck);
        check("post_reset_left_ws", 32'(ws), 32'd1);
        check("post_reset_left_underrun", 32'(underrun), 32'd1);
        repeat (32) @(negedge sck);
        check("post_reset_right_ws", 32'(ws), 32'd0);
        check("post_reset_right_underrun", 32'(underrun), 32'd1);

        push(CH_LEFT, 24'h13579B, 24'h13579B);
        push(CH_RIGHT, 24'h2468AC, 24'h2468AC);
        repeat (200) @(negedge sck);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
